// File: rtl/top.sv
// Multicycle RV32I-subset core (IF/ID/EX/MEM/WB, five cycles per instruction)
// with a 16 KiB unified, word-accessed instruction/data memory.

package top_pkg;

  typedef enum logic [2:0] {
    S_IF,
    S_ID,
    S_EX,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1,
    A_PC,
    A_ZERO
  } a_sel_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_sel_t;

  typedef struct packed {
    alu_op_t  alu_op;
    a_sel_t   a_sel;
    logic     b_imm;
    imm_sel_t imm_sel;
    logic     reg_write;
    logic     is_load;
    logic     is_store;
    logic     is_branch;
    logic     is_jal;
    logic     is_jalr;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INST_UNIMP = 32'hC000_1073;

endpackage

module core
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_data,
  input  logic [31:0] load_data,
  output logic [31:0] pc_reg,
  output logic [31:0] inst,
  output logic [31:0] addr_d,
  output logic        wen,
  output logic [31:0] wdata
);

  state_t      state, state_next;
  logic [31:0] regs [32];

  logic [4:0]  rs1_addr, rs2_addr, wb_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm;
  ctrl_t       ctrl;

  logic [31:0] alu_a, alu_b, alu_result, target;
  logic [4:0]  shamt;
  logic        taken, br_cond;
  logic [31:0] alu_q, target_q, load_q;
  logic        taken_q;
  logic        latch_inst, latch_ex, latch_mem, commit;

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IF;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    state_next = S_IF;
    unique case (state)
      S_IF:    state_next = S_ID;
      S_ID:    state_next = S_EX;
      S_EX:    state_next = S_MEM;
      S_MEM:   state_next = S_WB;
      default: state_next = S_IF;
    endcase
  end

  always_comb begin
    latch_inst = 1'b0;
    latch_ex   = 1'b0;
    latch_mem  = 1'b0;
    commit     = 1'b0;
    wen        = 1'b0;
    addr_d     = '0;
    wdata      = '0;
    unique case (state)
      S_IF: latch_inst = 1'b1;
      S_EX: latch_ex   = 1'b1;
      S_MEM: begin
        latch_mem = 1'b1;
        if (ctrl.is_load || ctrl.is_store) addr_d = rs1_data + imm;
        if (ctrl.is_store) begin
          wen   = 1'b1;
          wdata = rs2_data;
        end
      end
      S_WB:    commit = 1'b1;
      default: ;
    endcase
  end

  // ------------------------------------------------------------- decode
  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign rs1_addr = inst[19:15];
  assign rs2_addr = inst[24:20];
  assign wb_addr  = inst[11:7];

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

  always_comb begin
    imm = '0;
    unique case (ctrl.imm_sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

  // Anything not matched below leaves ctrl all-zero, which retires as a NOP.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_REG: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          ctrl.alu_op    = alu_from_f3(funct3, funct7[5]);
          ctrl.reg_write = 1'b1;
        end
      end
      OP_IMM: begin
        if (!(funct3 == 3'b001 && funct7 != 7'b0000000) &&
            !(funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)) begin
          ctrl.alu_op    = alu_from_f3(funct3, funct3 == 3'b101 && funct7[5]);
          ctrl.b_imm     = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          ctrl.is_load   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          ctrl.is_store = 1'b1;
          ctrl.imm_sel  = IMM_S;
        end
      end
      OP_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          ctrl.is_branch = 1'b1;
          ctrl.imm_sel   = IMM_B;
        end
      end
      OP_JAL: begin
        ctrl.is_jal    = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.reg_write = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl.is_jalr   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
      end
      OP_LUI: begin
        ctrl.a_sel     = A_ZERO;
        ctrl.b_imm     = 1'b1;
        ctrl.imm_sel   = IMM_U;
        ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.a_sel     = A_PC;
        ctrl.b_imm     = 1'b1;
        ctrl.imm_sel   = IMM_U;
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------- execute
  always_comb begin
    alu_a = rs1_data;
    unique case (ctrl.a_sel)
      A_PC:    alu_a = pc_reg;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_data;
    endcase
  end

  assign alu_b = ctrl.b_imm ? imm : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    unique case (ctrl.alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = 32'($signed(alu_a) >>> shamt);
      ALU_SLT:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'b0, alu_a < alu_b};
      default:  alu_result = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    unique case (funct3)
      3'b000:  br_cond = (rs1_data == rs2_data);
      3'b001:  br_cond = (rs1_data != rs2_data);
      3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_cond = (rs1_data <  rs2_data);
      3'b111:  br_cond = (rs1_data >= rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = ctrl.is_branch ? br_cond : (ctrl.is_jal || ctrl.is_jalr);
  assign target = ctrl.is_jalr ? ((rs1_data + imm) & ~32'd1) : (pc_reg + imm);

  always_comb begin
    wb_data = alu_q;
    if (ctrl.is_load)                    wb_data = load_q;
    else if (ctrl.is_jal || ctrl.is_jalr) wb_data = pc_reg + 32'd4;
  end

  // ------------------------------------------------------- datapath regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg   <= '0;
      inst     <= '0;
      alu_q    <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      load_q   <= '0;
    end else begin
      if (latch_inst) inst <= fetch_data;
      if (latch_ex) begin
        alu_q    <= alu_result;
        target_q <= target;
        taken_q  <= taken;
      end
      if (latch_mem) load_q <= load_data;
      if (commit)    pc_reg <= taken_q ? target_q : pc_reg + 32'd4;
    end
  end

  // NOTE: the register file is an array with an async reset, so it maps to
  // flops rather than RAM; clearing x1..x31 on reset requires that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (commit && ctrl.reg_write && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

module top
  import top_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic exit
);

  localparam int MEM_WORDS = 4096;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] pc_reg, inst, addr_d, wdata, fetch_data, load_data;
  logic        wen;
  logic        unused_addr_bits;

  core core0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_data (fetch_data),
    .load_data  (load_data),
    .pc_reg     (pc_reg),
    .inst       (inst),
    .addr_d     (addr_d),
    .wen        (wen),
    .wdata      (wdata)
  );

  // Word-only accesses: byte offset ignored, addresses above 16 KiB wrap.
  assign fetch_data = mem[pc_reg[13:2]];
  assign load_data  = mem[addr_d[13:2]];

  // Contents come from the program image and deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wen) mem[addr_d[13:2]] <= wdata;
  end

  assign exit = (inst == INST_UNIMP);

  assign unused_addr_bits = ^{pc_reg[31:14], pc_reg[1:0], addr_d[31:14], addr_d[1:0]};

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: expected retirements and stores are queued up
// front; monitors compare them as the core retires instructions.

module tb_top;
  import top_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic exit;

  top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .exit  (exit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    int          rd;
    logic [31:0] val;
    logic        ex;
  } ret_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  ret_t ret_q[$];
  st_t  st_q[$];
  ret_t r_cur;
  st_t  s_cur;
  logic ex_now;
  bit   mon_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic exp_ret(input string name, input logic [31:0] pc, input int rd,
                         input logic [31:0] val, input logic ex);
    ret_q.push_back('{name, pc, rd, val, ex});
  endtask

  task automatic load_image(input bit use_bne);
    for (int i = 0; i < 64; i++) dut.mem[i] = 32'h0000_0013;
    dut.mem[0]  = 32'h0050_0093;  // addi x1,x0,5
    dut.mem[1]  = 32'h0070_0113;  // addi x2,x0,7
    dut.mem[2]  = 32'h0020_81B3;  // add  x3,x1,x2
    dut.mem[3]  = 32'h0030_2823;  // sw   x3,16(x0)  overwrites word 4
    dut.mem[4]  = 32'h0010_0293;  // addi x5,x0,1   (never fetched as such)
    dut.mem[5]  = 32'h0100_2203;  // lw   x4,16(x0)
    dut.mem[6]  = 32'hC000_1073;  // unimp
    dut.mem[7]  = 32'h0090_0013;  // addi x0,x0,9
    dut.mem[8]  = use_bne ? 32'h0010_9463 : 32'h0010_8463;  // bne/beq x1,x1,+8
    dut.mem[9]  = 32'h0010_0313;  // addi x6,x0,1
    dut.mem[10] = 32'h0080_006F;  // jal  x0,+8
    dut.mem[12] = 32'h0100_00EF;  // jal  x1,+16
    dut.mem[16] = 32'h0000_006F;  // jal  x0,0
  endtask

  task automatic exp_common();
    exp_ret("addi_x1",     32'h04, 1, 32'h05, 1'b0);
    exp_ret("addi_x2",     32'h08, 2, 32'h07, 1'b0);
    exp_ret("add_x3",      32'h0C, 3, 32'h0C, 1'b0);
    exp_ret("sw",          32'h10, 3, 32'h0C, 1'b0);
    exp_ret("patched_nop", 32'h14, 5, 32'h00, 1'b0);
    exp_ret("lw_x4",       32'h18, 4, 32'h0C, 1'b0);
    exp_ret("unimp",       32'h1C, 0, 32'h00, 1'b1);
    exp_ret("addi_x0",     32'h20, 0, 32'h00, 1'b0);
    st_q.push_back('{32'd16, 32'h0000_000C});
  endtask

  task automatic drain(input string name, input int budget);
    int b = budget;
    while ((ret_q.size() + st_q.size()) != 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    #2;
    check({name, "_drained"}, 32'(ret_q.size() + st_q.size()), 32'd0);
    mon_en = 1'b0;
    ret_q.delete();
    st_q.delete();
  endtask

  // Retirement monitor: exit sampled during WB, pc/rd after the WB edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && dut.core0.state == S_WB) begin
      ex_now = exit;
      @(posedge clk);
      #1;
      if (mon_en && rst_n) begin
        check("retire_expected", 32'(ret_q.size() != 0), 32'd1);
        if (ret_q.size() != 0) begin
          r_cur = ret_q.pop_front();
          check({r_cur.name, "_pc"},   dut.core0.pc_reg,         r_cur.pc);
          check({r_cur.name, "_rd"},   dut.core0.regs[r_cur.rd], r_cur.val);
          check({r_cur.name, "_exit"}, 32'(ex_now),              32'(r_cur.ex));
        end
      end
    end
  end

  // Store monitor: every cycle with wen high must match a queued store.
  always @(negedge clk) begin
    if (mon_en && rst_n && dut.core0.wen) begin
      check("store_expected", 32'(st_q.size() != 0), 32'd1);
      if (st_q.size() != 0) begin
        s_cur = st_q.pop_front();
        check("store_in_mem", 32'(dut.core0.state == S_MEM), 32'd1);
        check("store_addr",   dut.core0.addr_d, s_cur.addr);
        check("store_wdata",  dut.core0.wdata,  s_cur.data);
      end
    end
  end

  initial begin
    logic [31:0] acc;
    int b;

    // ---- run 1: arithmetic, store/load, self-modify, exit, beq, jal
    load_image(1'b0);
    exp_common();
    exp_ret("beq",    32'h28, 1, 32'h05, 1'b0);
    exp_ret("jal_x0", 32'h30, 1, 32'h05, 1'b0);
    exp_ret("jal_x1", 32'h40, 1, 32'h34, 1'b0);
    exp_ret("loop",   32'h40, 6, 32'h00, 1'b0);
    #12;
    check("rst_pc",   dut.core0.pc_reg, 32'h0);
    check("rst_inst", dut.core0.inst,   32'h0);
    check("rst_exit", 32'(exit),        32'd0);
    check("rst_wen",  32'(dut.core0.wen), 32'd0);

    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch_inst", dut.core0.inst,   32'h0050_0093);
    check("first_fetch_pc",   dut.core0.pc_reg, 32'h0);
    repeat (14) @(posedge clk);
    #1;
    check("cyc15_x3", dut.core0.regs[3], 32'h0000_000C);
    check("cyc15_pc", dut.core0.pc_reg,  32'h0000_000C);
    drain("run1", 100);

    // ---- run 2: bne not taken falls through to addi x6
    @(negedge clk);
    rst_n = 1'b0;
    load_image(1'b1);
    exp_common();
    exp_ret("bne",     32'h24, 1, 32'h05, 1'b0);
    exp_ret("addi_x6", 32'h28, 6, 32'h01, 1'b0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drain("run2", 80);

    // ---- asynchronous reset in the middle of EX
    b = 0;
    while (dut.core0.state != S_EX && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("reach_ex", 32'(dut.core0.state == S_EX), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.core0.regs[i];
    check("async_rst_pc",    dut.core0.pc_reg, 32'h0);
    check("async_rst_regs",  acc,              32'h0);
    check("async_rst_inst",  dut.core0.inst,   32'h0);
    check("async_rst_state", 32'(dut.core0.state == S_IF), 32'd1);
    check("async_rst_exit",  32'(exit),        32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset; asynchronous and active-low.
REQ-003 SHALL: exit  output  1  high while the currently latched instruction equals 32'hC0001073 (unimp), marking end of program.
REQ-004 SHALL: top contains a core instance named core0 and a unified instruction/data memory; core0 SHALL expose these signals:
- pc_reg (32)
- inst (32, instruction register)
- rs1_addr, rs2_addr, wb_addr (5 each)
- rs1_data, rs2_data, wb_data (32)
- addr_d (32, data address)
- wen (1, data write enable)
- wdata (32, store data)

Function
REQ-005 SHALL: multicycle, non-pipelined RV32I subset core; exactly 5 cycles per instruction, states IF -> ID -> EX -> MEM -> WB -> IF.
REQ-006 SHALL: IF state: the memory word at pc_reg is latched into inst at the end of IF.
REQ-007 SHALL: ID state: decode fields:
- rs1_addr=inst[19:15], rs2_addr=inst[24:20], wb_addr=inst[11:7]
- rs1_data/rs2_data read combinationally from the register file
- reads of x0 return 0
REQ-008 SHALL: immediates are sign-extended per RISC-V I, S, B, J and U formats.
REQ-009 SHALL: supported instructions, all arithmetic 32-bit modulo 2^32:
- LW, SW
- ADD, SUB, ADDI
- AND, OR, XOR, ANDI, ORI, XORI
- SLL, SRL, SRA, SLLI, SRLI, SRAI (shift amount = low 5 bits)
- SLT, SLTU, SLTI, SLTIU
- BEQ, BNE, BLT, BGE, BLTU, BGEU
- JAL, JALR, LUI, AUIPC
REQ-010 SHALL: unsupported or illegal encodings execute as NOP (pc+4, no writes).
REQ-011 SHALL: EX state computes the ALU result, the branch decision and the jump target:
- JALR target = (rs1+imm) with bit0 cleared
- branch/JAL target = pc+imm
REQ-012 SHALL: MEM state behaviour:
- addr_d = rs1_data+imm for LW/SW, else 0.
- SW drives wen=1 and wdata=rs2_data for that single cycle only.
- wen=0 in all other states and for all other instructions.
REQ-013 SHALL: memory is byte-addressed, little-endian, 16 KiB; only word accesses are supported; address bits [1:0] are ignored; address bits above [13:0] wrap.
REQ-014 SHALL: memory contents are preloaded from a hex image at time zero and are not affected by reset.
REQ-015 SHALL: WB state, wb_data selection:
- loaded word for LW
- pc+4 for JAL/JALR
- ALU result otherwise
REQ-016 SHALL: at the edge leaving WB, the register file is written when the instruction writes rd and wb_addr != 0; writes to x0 are discarded.
REQ-017 SHALL: at the edge leaving WB, pc_reg <= taken branch/jump target, else pc_reg+4.
REQ-018 SHALL: a store followed by a load to the same address returns the stored word; a store to the instruction area is visible at the next fetch.
REQ-019 SHALL: after exit asserts, the core keeps executing (exit is a flag only); exit deasserts if inst changes.

Reset
REQ-020 SHALL: on rst_n=0 asynchronously:
- pc_reg=0, inst=0, state=IF
- x1..x31=0
- wen=0, exit=0
REQ-021 SHALL: on release of rst_n, the first rising edge begins IF of address 0.
REQ-022 SHALL: reset asserted mid-instruction aborts that instruction with no register or memory write.

Verification
REQ-023 SHALL: bench covers: image {ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2} -> after 15 cycles x3=0x0000000C and pc_reg=0x0000000C.
REQ-024 SHALL: bench covers: SW x3,16(x0) then LW x4,16(x0) -> during the SW MEM cycle wen=1, addr_d=16, wdata=0x0C; afterwards x4=0x0C.
REQ-025 SHALL: bench covers: BEQ x1,x1,+8 at pc 0x20 -> next pc_reg=0x28; BNE x1,x1,+8 -> next pc_reg=0x24.
REQ-026 SHALL: bench covers: JAL x1,+16 at pc 0x30 -> x1=0x34, pc_reg=0x40; ADDI x0,x0,9 -> x0 remains 0.
REQ-027 SHALL: bench covers: word 0xC0001073 reached -> exit=1 while it is in inst.
REQ-028 SHALL: bench covers: rst_n pulsed low mid-EX -> pc_reg=0 and registers=0 immediately, without waiting for a clock edge.
